// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SRAM responder.
package sram_resp_pkg;

  typedef enum logic {
    StClear,
    StReady
  } state_e;

  localparam logic [31:0] DefaultBase = 32'h1c000000;

endpackage

// File: rtl/sram_byte_array.sv
// Word-organised storage with per-byte write enables and a synchronous
// read-first port. No reset: contents persist across resets.
module sram_byte_array #(
  parameter int unsigned AddrW = 12,
  parameter int unsigned Depth = 2 ** AddrW
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [3:0]       we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem [Depth];
  logic [31:0] rdata_q;

  // Read data captures the pre-write word when a lane is written in the same cycle.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem[addr_i];
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Single-port SRAM responder: address decode relative to BASE, optional
// post-reset zero fill, one-cycle read latency and out-of-range flagging.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter logic [31:0] BASE           = DefaultBase,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              rsel_q, rsel_d;
  logic              err_q, err_d;

  logic [31:0]       offset;
  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic              unused_offset;

  logic              arr_en;
  logic [3:0]        arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [31:0]       arr_wdata;
  logic [31:0]       arr_rdata;

  // Subtraction wraps mod 2^32, so addresses below BASE land far out of range.
  assign offset        = sram_addr - BASE;
  assign in_range      = (offset[31:ADDR_W+2] == '0);
  assign word_idx      = offset[ADDR_W+1:2];
  assign unused_offset = ^offset[1:0];

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    rsel_d    = rsel_q;
    err_d     = 1'b0;
    arr_en    = 1'b0;
    arr_we    = 4'h0;
    arr_addr  = word_idx;
    arr_wdata = sram_wdata;

    unique case (state_q)
      StClear: begin
        arr_en    = 1'b1;
        arr_we    = 4'hF;
        arr_addr  = clr_idx_q;
        arr_wdata = '0;
        rsel_d    = 1'b0;
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (&clr_idx_q) begin
          state_d   = StReady;
          clr_idx_d = '0;
        end
      end
      StReady: begin
        if (sram_en) begin
          if (in_range) begin
            arr_en = 1'b1;
            arr_we = sram_we;
            rsel_d = 1'b1;
          end else begin
            rsel_d = 1'b0;
            err_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= CLEAR_ON_RESET ? StClear : StReady;
      clr_idx_q <= '0;
      rsel_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rsel_q    <= rsel_d;
      err_q     <= err_d;
    end
  end

  sram_byte_array #(
    .AddrW (ADDR_W),
    .Depth (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .en_i    (arr_en),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  // Array read data is only exposed after an in-range access; otherwise zero.
  assign sram_rdata = rsel_q ? arr_rdata : '0;
  assign busy       = (state_q == StClear);
  assign addr_err   = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder (ADDR_W=4) with a scoreboard of expected responses.
module tb_sram_responder;

  localparam int unsigned AW   = 4;
  localparam logic [31:0] BASE = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_we = 4'h0;
  logic [31:0] sram_addr = '0;
  logic [31:0] sram_wdata = '0;
  logic [31:0] sram_rdata;
  logic        busy;
  logic        addr_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [16];
  logic [31:0] last_rd = '0;
  logic [31:0] exp_rd_q [$];
  logic        exp_err_q [$];

  always #5 clk = ~clk;

  sram_responder #(
    .ADDR_W         (AW),
    .BASE           (BASE),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .busy       (busy),
    .addr_err   (addr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict the response, then compare after the edge.
  task automatic req(input string tag, input logic en, input logic [3:0] we,
                     input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] off;
    logic [31:0] e;
    int          idx;
    off = addr - BASE;
    idx = int'(off[5:2]);
    if (!en) begin
      exp_rd_q.push_back(last_rd);
      exp_err_q.push_back(1'b0);
    end else if (off[31:6] != '0) begin
      last_rd = '0;
      exp_rd_q.push_back('0);
      exp_err_q.push_back(1'b1);
    end else begin
      e = model[idx];
      for (int i = 0; i < 4; i++) if (we[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
      last_rd = e;
      exp_rd_q.push_back(e);
      exp_err_q.push_back(1'b0);
    end
    sram_en    = en;
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wd;
    @(posedge clk);
    #1;
    check({tag, ".rdata"}, sram_rdata, exp_rd_q.pop_front());
    check({tag, ".err"}, {31'b0, addr_err}, {31'b0, exp_err_q.pop_front()});
  endtask

  // Count busy cycles after reset release while hammering word 0 with a write.
  task automatic wait_clear(input string tag);
    int n;
    n          = 0;
    sram_en    = 1'b1;
    sram_we    = 4'hF;
    sram_addr  = BASE;
    sram_wdata = 32'hCAFEF00D;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) begin
        check({tag, ".busy_rdata"}, sram_rdata, 32'h0);
        check({tag, ".busy_err"}, {31'b0, addr_err}, 32'h0);
      end
    end
    sram_en = 1'b0;
    sram_we = 4'h0;
    check({tag, ".busy_cycles"}, n, 32'd16);
    for (int i = 0; i < 16; i++) model[i] = '0;
    last_rd = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;

    #1;
    check("rst.busy", {31'b0, busy}, 32'h1);
    check("rst.rdata", sram_rdata, 32'h0);
    check("rst.err", {31'b0, addr_err}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_clear("clr1");

    for (int i = 0; i < 16; i++) req("zero_rd", 1'b1, 4'h0, BASE + 32'(4 * i), '0);

    req("wr_full", 1'b1, 4'hF, 32'h1c000008, 32'hDEADBEEF);
    req("rd_full", 1'b1, 4'h0, 32'h1c000008, '0);
    req("wr_lane", 1'b1, 4'b0101, 32'h1c000008, 32'h11223344);
    req("rd_lane", 1'b1, 4'h0, 32'h1c000008, '0);
    req("idle_hold", 1'b0, 4'h0, 32'h1c000008, '0);
    req("oor_low", 1'b1, 4'h0, 32'h1bfffffc, '0);
    req("oor_high", 1'b1, 4'hF, 32'h1c000040, 32'h55555555);
    req("idle_err", 1'b0, 4'h0, '0, '0);
    req("rd_after_oor", 1'b1, 4'h0, 32'h1c000008, '0);
    req("rd_word0", 1'b1, 4'h0, 32'h1c000000, '0);
    req("wr_last", 1'b1, 4'hF, 32'h1c00003c, 32'hAABBCCDD);
    req("rd_last", 1'b1, 4'h0, 32'h1c00003c, '0);
    req("wr_b2b", 1'b1, 4'b1000, 32'h1c00003c, 32'h01000000);
    req("rd_b2b", 1'b1, 4'h0, 32'h1c00003c, '0);
    req("rd_unaligned", 1'b1, 4'h0, 32'h1c00000b, '0);
    req("idle_end", 1'b0, 4'h0, '0, '0);

    // Reset again, then interrupt the fill part way through.
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("midrst.busy", {31'b0, busy}, 32'h1);
    check("midrst.rdata", sram_rdata, 32'h0);
    check("midrst.err", {31'b0, addr_err}, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_clear("clr2");
    req("rd_w0_after", 1'b1, 4'h0, 32'h1c000000, '0);
    req("rd_w2_after", 1'b1, 4'h0, 32'h1c000008, '0);
    req("rd_w15_after", 1'b1, 4'h0, 32'h1c00003c, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
